// File: rtl/fpu_sched_pkg.sv
// Shared opcodes, FSM encoding and sizing constants for fpu_scheduler.
package fpu_sched_pkg;

    localparam logic [1:0] OP_FADD    = 2'd0;
    localparam logic [1:0] OP_FSUB    = 2'd1;
    localparam logic [1:0] OP_FCONV   = 2'd2;
    localparam logic [1:0] OP_ILLEGAL = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } schedState_t;

    // Latency counter width, wide enough for LATENCY up to 15.
    localparam int unsigned CNT_W = 4;

    // True when the opcode is executed by the add/sub unit.
    function automatic logic usesAdder(input logic [1:0] opcode);
        return (opcode == OP_FADD) || (opcode == OP_FSUB);
    endfunction

endpackage

// File: rtl/fpu_scheduler_rr_arbiter.sv
// Round-robin arbiter: searches from ptr+1 upwards (mod NREQ) for the first request.
module rr_arbiter #(
    parameter int unsigned NREQ = 2
) (
    input  logic [NREQ-1:0]          req,
    input  logic [$clog2(NREQ)-1:0]  ptr,
    output logic [NREQ-1:0]          winner,
    output logic [$clog2(NREQ)-1:0]  winnerIdx,
    output logic                     anyReq
);

    localparam int unsigned IDX_W = $clog2(NREQ);

    logic             found;
    logic [IDX_W-1:0] cand;

    // Pick the first active request after the previous winner.
    always_comb begin
        winner    = '0;
        winnerIdx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 1; k <= int'(NREQ); k++) begin
            cand = IDX_W'((int'(ptr) + k) % int'(NREQ));
            if (!found && req[cand]) begin
                found        = 1'b1;
                winner[cand] = 1'b1;
                winnerIdx    = cand;
            end
        end
        anyReq = |req;
    end

endmodule

// File: rtl/fpu_scheduler.sv
// fpu_scheduler: shares one FP add/sub unit and one int-to-float converter
// between NREQ requesters, one operation in flight, round-robin arbitration.
// Optional statistics counters enabled by defining FPU_SCHED_STATS_EN.
module fpu_scheduler
    import fpu_sched_pkg::*;
#(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned LATENCY = 4,
    parameter int unsigned WIDTH   = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [2*NREQ-1:0]       op,
    input  logic [WIDTH*NREQ-1:0]   opa,
    input  logic [WIDTH*NREQ-1:0]   opb,
    output logic [NREQ-1:0]         grant,
    output logic [NREQ-1:0]         done,
    output logic [WIDTH-1:0]        result,
    output logic                    err,
    output logic                    busy,
    output logic [WIDTH-1:0]        fu_a,
    output logic [WIDTH-1:0]        fu_b,
    output logic                    fu_sub,
    output logic                    fu_add_en,
    output logic                    fu_conv_en,
    input  logic [WIDTH-1:0]        fu_add_result,
    input  logic [WIDTH-1:0]        fu_conv_result,
    output logic [31:0]             stat_ops,
    output logic [31:0]             stat_busy
);

    localparam int unsigned IDX_W = $clog2(NREQ);

    schedState_t      state, stateNext;
    logic [IDX_W-1:0] ptr, ptrNext, winIdx;
    logic [NREQ-1:0]  winner;
    logic             anyReq;
    logic [1:0]       curOp, curOpNext, selOp;
    logic [CNT_W-1:0] cnt, cntNext;
    logic [WIDTH-1:0] selA, selB;

    logic [NREQ-1:0]  grantNext, doneNext;
    logic [WIDTH-1:0] resultNext, fuANext, fuBNext;
    logic             errNext, busyNext, fuSubNext, addEnNext, convEnNext;

    rr_arbiter #(.NREQ(NREQ)) uArb (
        .req       (req),
        .ptr       (ptr),
        .winner    (winner),
        .winnerIdx (winIdx),
        .anyReq    (anyReq)
    );

    // Route the winning requester's opcode and operands.
    always_comb begin
        selOp = OP_FADD;
        selA  = '0;
        selB  = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (winner[i]) begin
                selOp = op[2*i +: 2];
                selA  = opa[WIDTH*i +: WIDTH];
                selB  = opb[WIDTH*i +: WIDTH];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= stateNext;
    end

    // Next-state logic.
    always_comb begin
        stateNext = state;
        case (state)
            S_IDLE:  if (anyReq) stateNext = S_ISSUE;
            S_ISSUE: stateNext = (curOp == OP_ILLEGAL) ? S_DONE : S_WAIT;
            S_WAIT:  if (cnt == CNT_W'(1)) stateNext = S_DONE;
            S_DONE:  stateNext = S_IDLE;
            default: stateNext = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath.
    always_comb begin
        ptrNext    = ptr;
        curOpNext  = curOp;
        cntNext    = cnt;
        grantNext  = grant;
        doneNext   = '0;
        resultNext = result;
        errNext    = 1'b0;
        fuANext    = fu_a;
        fuBNext    = fu_b;
        fuSubNext  = fu_sub;
        addEnNext  = fu_add_en;
        convEnNext = fu_conv_en;
        busyNext   = (stateNext != S_IDLE);
        case (state)
            S_IDLE: begin
                if (anyReq) begin
                    grantNext  = winner;
                    ptrNext    = winIdx;
                    curOpNext  = selOp;
                    fuANext    = selA;
                    fuBNext    = selB;
                    fuSubNext  = (selOp == OP_FSUB);
                    addEnNext  = usesAdder(selOp);
                    convEnNext = (selOp == OP_FCONV);
                end
            end
            S_ISSUE: begin
                cntNext = CNT_W'(LATENCY);
                if (curOp == OP_ILLEGAL) begin
                    grantNext  = '0;
                    doneNext   = grant;
                    resultNext = '0;
                    errNext    = 1'b1;
                end
            end
            S_WAIT: begin
                cntNext = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    grantNext  = '0;
                    doneNext   = grant;
                    addEnNext  = 1'b0;
                    convEnNext = 1'b0;
                    resultNext = (curOp == OP_FCONV) ? fu_conv_result : fu_add_result;
                end
            end
            default: ;
        endcase
    end

    // Output and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr        <= IDX_W'(NREQ - 1);
            curOp      <= OP_FADD;
            cnt        <= '0;
            grant      <= '0;
            done       <= '0;
            result     <= '0;
            err        <= 1'b0;
            busy       <= 1'b0;
            fu_a       <= '0;
            fu_b       <= '0;
            fu_sub     <= 1'b0;
            fu_add_en  <= 1'b0;
            fu_conv_en <= 1'b0;
        end else begin
            ptr        <= ptrNext;
            curOp      <= curOpNext;
            cnt        <= cntNext;
            grant      <= grantNext;
            done       <= doneNext;
            result     <= resultNext;
            err        <= errNext;
            busy       <= busyNext;
            fu_a       <= fuANext;
            fu_b       <= fuBNext;
            fu_sub     <= fuSubNext;
            fu_add_en  <= addEnNext;
            fu_conv_en <= convEnNext;
        end
    end

`ifdef FPU_SCHED_STATS_EN
    // Completed-operation and busy-cycle counters, wrapping at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_ops  <= '0;
            stat_busy <= '0;
        end else begin
            if (|done) stat_ops  <= stat_ops + 32'd1;
            if (busy)  stat_busy <= stat_busy + 32'd1;
        end
    end
`else
    assign stat_ops  = '0;
    assign stat_busy = '0;
`endif

endmodule

// File: tb/tb_fpu_scheduler.sv
// Self-checking bench for fpu_scheduler with behavioural add and convert units.
module tb_fpu_scheduler;

    localparam int unsigned NREQ    = 3;
    localparam int unsigned LATENCY = 4;
    localparam int unsigned WIDTH   = 32;

    logic                  clk, reset;
    logic [NREQ-1:0]       req;
    logic [2*NREQ-1:0]     op;
    logic [WIDTH*NREQ-1:0] opa, opb;
    logic [NREQ-1:0]       grant, done;
    logic [WIDTH-1:0]      result, fu_a, fu_b, fu_add_result, fu_conv_result;
    logic                  err, busy, fu_sub, fu_add_en, fu_conv_en;
    logic [31:0]           stat_ops, stat_busy;

    fpu_scheduler #(.NREQ(NREQ), .LATENCY(LATENCY), .WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .req(req), .op(op), .opa(opa), .opb(opb),
        .grant(grant), .done(done), .result(result), .err(err), .busy(busy),
        .fu_a(fu_a), .fu_b(fu_b), .fu_sub(fu_sub), .fu_add_en(fu_add_en),
        .fu_conv_en(fu_conv_en), .fu_add_result(fu_add_result),
        .fu_conv_result(fu_conv_result), .stat_ops(stat_ops), .stat_busy(stat_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Single-precision <-> real helpers (normal numbers and zero only).
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) return 0.0;
        d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        d = $realtobits(r);
        if (r == 0.0) return 32'd0;
        return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
    endfunction

    function automatic logic [31:0] refResult(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        case (o)
            2'd0:    return r2f(f2r(a) + f2r(b));
            2'd1:    return r2f(f2r(a) - f2r(b));
            2'd2:    return r2f(real'($signed(a)));
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] randFloat();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 140)), 23'($urandom)};
    endfunction

    // Behavioural units: result appears LATENCY enabled cycles after enable.
    logic [WIDTH-1:0] addPipe  [LATENCY];
    logic [WIDTH-1:0] convPipe [LATENCY];
    always @(posedge clk) begin
        if (fu_add_en) begin
            addPipe[0] <= r2f(fu_sub ? f2r(fu_a) - f2r(fu_b) : f2r(fu_a) + f2r(fu_b));
            for (int i = 1; i < int'(LATENCY); i++) addPipe[i] <= addPipe[i-1];
        end
        if (fu_conv_en) begin
            convPipe[0] <= r2f(real'($signed(fu_a)));
            for (int i = 1; i < int'(LATENCY); i++) convPipe[i] <= convPipe[i-1];
        end
    end
    assign fu_add_result  = addPipe[LATENCY-1];
    assign fu_conv_result = convPipe[LATENCY-1];

    task automatic checkVal(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Reference state: round-robin pointer, per-requester transactions, statistics.
    int          ptrModel;
    int          modelOps, modelBusy;
    logic [1:0]  curOpArr [NREQ];
    logic [31:0] curA     [NREQ];
    logic [31:0] curB     [NREQ];
    logic [31:0] obsResult[NREQ];
    logic        obsErr   [NREQ];
    int          grantLog [$];
    bit          randomMode = 1'b0;

    function automatic int modelWinner(input logic [NREQ-1:0] pend);
        for (int k = 1; k <= int'(NREQ); k++) begin
            int i = (ptrModel + k) % int'(NREQ);
            if (pend[i]) return i;
        end
        return -1;
    endfunction

    function automatic int onehotIdx(input logic [NREQ-1:0] v);
        for (int i = 0; i < int'(NREQ); i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic checkStats();
`ifdef FPU_SCHED_STATS_EN
        checkVal("stat_ops", stat_ops, 32'(modelOps));
        checkVal("stat_busy", stat_busy, 32'(modelBusy));
`else
        checkVal("stat_ops_tied", stat_ops, 32'd0);
        checkVal("stat_busy_tied", stat_busy, 32'd0);
`endif
    endtask

    // Raise all requesters in mask at once and follow every grant/done until all complete.
    task automatic runRound(input logic [NREQ-1:0] mask);
        logic [NREQ-1:0] pending, prevGrant;
        logic [31:0]     expRes, lastRes;
        logic [1:0]      ownOp;
        int cyc, grantCyc, lastDone, owner, addCnt, convCnt, w, expW;
        bit multi;
        pending = mask; prevGrant = '0; owner = -1; lastDone = -1; multi = 1'b0;
        addCnt = 0; convCnt = 0; grantCyc = 0; cyc = 0; expRes = '0; ownOp = 2'd0; lastRes = result;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (mask[i]) begin
                req[i]              = 1'b1;
                op[2*i +: 2]        = curOpArr[i];
                opa[WIDTH*i +: WIDTH] = curA[i];
                opb[WIDTH*i +: WIDTH] = curB[i];
            end
        end
        while (pending != '0 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if ($countones(grant) > 1) multi = 1'b1;
            if (owner >= 0) begin
                addCnt  += int'(fu_add_en);
                convCnt += int'(fu_conv_en);
            end
            if (grant != '0 && prevGrant == '0) begin
                w    = onehotIdx(grant);
                expW = modelWinner(pending);
                ptrModel = expW;
                checkVal("grant_winner", 32'(w), 32'(expW));
                checkVal("grant_latency", 32'(cyc), 32'(lastDone + 2));
                checkVal("busy_grant", 32'(busy), 32'd1);
                if (w >= 0) begin
                    ownOp  = curOpArr[w];
                    expRes = refResult(ownOp, curA[w], curB[w]);
                    checkVal("fu_a_latched", fu_a, curA[w]);
                    checkVal("fu_b_latched", fu_b, curB[w]);
                    if (ownOp == 2'd0 || ownOp == 2'd1)
                        checkVal("fu_sub", 32'(fu_sub), 32'(ownOp == 2'd1));
                    grantLog.push_back(w);
                    owner    = w;
                    grantCyc = cyc;
                    addCnt   = int'(fu_add_en);
                    convCnt  = int'(fu_conv_en);
                    if (randomMode && $urandom_range(0, 2) == 0) begin
                        opa[WIDTH*w +: WIDTH] = $urandom;
                        op[2*w +: 2]          = 2'($urandom);
                    end
                    if (randomMode && $urandom_range(0, 3) == 0) req[w] = 1'b0;
                end
            end
            if (done != '0) begin
                if (owner < 0) begin
                    checkVal("spurious_done", 32'(done), 32'd0);
                end else begin
                    checkVal("done_who", 32'(done), 32'd1 << owner);
                    checkVal("done_latency", 32'(cyc - grantCyc),
                             (ownOp == 2'd3) ? 32'd1 : 32'(LATENCY + 1));
                    checkVal("result", result, expRes);
                    checkVal("err", 32'(err), 32'(ownOp == 2'd3));
                    checkVal("grant_at_done", 32'(grant), 32'd0);
                    checkVal("add_en_cycles", 32'(addCnt),
                             (ownOp <= 2'd1) ? 32'(LATENCY + 1) : 32'd0);
                    checkVal("conv_en_cycles", 32'(convCnt),
                             (ownOp == 2'd2) ? 32'(LATENCY + 1) : 32'd0);
                    obsResult[owner] = result;
                    obsErr[owner]    = err;
                    lastRes          = expRes;
                    modelOps++;
                    modelBusy += (ownOp == 2'd3) ? 2 : int'(LATENCY) + 2;
                    req[owner]     = 1'b0;
                    pending[owner] = 1'b0;
                    lastDone       = cyc;
                    owner          = -1;
                end
            end
            prevGrant = grant;
        end
        checkVal("round_timeout", 32'(pending), 32'd0);
        checkVal("grant_onehot", 32'(multi), 32'd0);
        @(posedge clk); #1;
        checkVal("done_pulse", 32'(done), 32'd0);
        checkVal("err_pulse", 32'(err), 32'd0);
        checkVal("busy_idle", 32'(busy), 32'd0);
        checkVal("result_hold", result, lastRes);
        checkStats();
    endtask

    initial begin
        reset = 1'b1; req = '0; op = '0; opa = '0; opb = '0;
        modelOps = 0; modelBusy = 0; ptrModel = int'(NREQ) - 1;
        repeat (2) @(posedge clk);
        #1;
        checkVal("rst_grant", 32'(grant), 32'd0);
        checkVal("rst_done", 32'(done), 32'd0);
        checkVal("rst_busy", 32'(busy), 32'd0);
        checkVal("rst_result", result, 32'd0);
        checkVal("rst_en", 32'({fu_add_en, fu_conv_en, fu_sub}), 32'd0);
        checkStats();
        reset = 1'b0;
        @(posedge clk); #1;

        // Int-to-float of 21.
        curOpArr[0] = 2'd2; curA[0] = 32'd21; curB[0] = 32'd0;
        runRound(3'b001);
        checkVal("s1_result", obsResult[0], 32'h41A80000);
        checkVal("s1_err", 32'(obsErr[0]), 32'd0);

        // 21.0 + 35.0
        curOpArr[1] = 2'd0; curA[1] = 32'h41A80000; curB[1] = 32'h420C0000;
        runRound(3'b010);
        checkVal("s2_result", obsResult[1], 32'h42600000);

        // 1000.0 - (-10.0)
        curOpArr[0] = 2'd1; curA[0] = 32'h447A0000; curB[0] = 32'hC1200000;
        runRound(3'b001);
        checkVal("s3_result", obsResult[0], 32'h447C8000);

        // Illegal opcode.
        curOpArr[1] = 2'd3; curA[1] = 32'h12345678; curB[1] = 32'h9ABCDEF0;
        runRound(3'b010);
        checkVal("s5_result", obsResult[1], 32'd0);
        checkVal("s5_err", 32'(obsErr[1]), 32'd1);

        // Asynchronous reset in the middle of WAIT.
        curOpArr[0] = 2'd0; curA[0] = randFloat(); curB[0] = randFloat();
        req[0] = 1'b1; op[1:0] = curOpArr[0]; opa[31:0] = curA[0]; opb[31:0] = curB[0];
        repeat (3) @(posedge clk);
        #3;
        checkVal("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        checkVal("async_grant", 32'(grant), 32'd0);
        checkVal("async_busy", 32'(busy), 32'd0);
        checkVal("async_add_en", 32'(fu_add_en), 32'd0);
        checkVal("async_fu_a", fu_a, 32'd0);
        checkVal("async_fu_b", fu_b, 32'd0);
        checkVal("async_result", result, 32'd0);
        req = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        ptrModel = int'(NREQ) - 1; modelOps = 0; modelBusy = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checkVal("no_done_after_reset", 32'(done), 32'd0);
        end
        checkStats();

        // Two requesters held together: grants must alternate starting at 0.
        grantLog.delete();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 2; i++) begin
                curOpArr[i] = 2'($urandom_range(0, 1)); curA[i] = randFloat(); curB[i] = randFloat();
            end
            runRound(3'b011);
        end
        checkVal("s4_count", 32'(grantLog.size()), 32'd4);
        for (int k = 0; k < grantLog.size(); k++)
            checkVal("s4_order", 32'(grantLog[k]), 32'(k % 2));
`ifdef FPU_SCHED_STATS_EN
        checkVal("s4_stat_ops", stat_ops, 32'd4);
`endif

        // Randomized rounds.
        randomMode = 1'b1;
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                curOpArr[i] = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                curA[i]     = (curOpArr[i] == 2'd2) ? $urandom : randFloat();
                curB[i]     = randFloat();
            end
            runRound(NREQ'($urandom_range(1, (1 << NREQ) - 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
